async_fifo_wr_arbiter: RTL and testbench

Round-robin write-side arbiter that shares the single write port of an `async_fifo` between `NREQ` requesters in the write clock domain. Each requester pushes packets (one or more beats) over a valid/ready handshake. The arbiter locks the grant for a whole packet so beats from different requesters never interleave in the FIFO. Each beat is tagged with the requester index, and `wfull`/`awfull` back-pressure is honoured so the FIFO never overflows.

---
 rtl/async_fifo_pkg.sv | 22 ++
 rtl/rr_pick.sv | 28 ++
 rtl/async_fifo_wr_arbiter.sv | 115 +++++++++++
 tb/tb_async_fifo_wr_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared types and wdata field layout for the async_fifo write side
package async_fifo_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  // wdata is {id, last, payload}; offsets for the default payload width
  localparam int DSIZE_DEF = 32;
  localparam int LAST_BIT  = DSIZE_DEF;
  localparam int ID_LSB    = DSIZE_DEF + 1;

  function automatic int wd_last_bit(input int dsize);
    return dsize;
  endfunction

  function automatic int wd_id_lsb(input int dsize);
    return dsize + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector, search starts one past ptr
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  gnt_id,
  output logic            any
);

  logic [IDW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_id = '0;
    any    = 1'b0;
    idx    = '0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = IDW'((int'(ptr) + off) % NREQ);
      if (req[idx]) begin
        gnt_id = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// rtl/async_fifo_wr_arbiter.sv - packet-locked round-robin arbiter for the async_fifo write port
module async_fifo_wr_arbiter
  import async_fifo_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 32,
  parameter int MAX_BURST = 8,
  parameter int USE_AFULL = 1,
  parameter int IDW       = $clog2(NREQ)
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic                  winc,
  output logic [IDW+DSIZE:0]    wdata,
  input  logic                  wfull,
  input  logic                  awfull,
  output logic                  grant_vld,
  output logic [IDW-1:0]        grant_id
);

  localparam int BCW = $clog2(MAX_BURST + 1);
  localparam int WD_LAST = wd_last_bit(DSIZE);
  localparam int WD_ID   = wd_id_lsb(DSIZE);
  localparam logic [BCW-1:0] BEAT_MAX = BCW'(MAX_BURST - 1);

  arb_state_e       state_q;
  logic [IDW-1:0]   grant_id_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [BCW-1:0]   beat_cnt_q;
  logic             grant_vld_q;

  logic [IDW-1:0]   pick_id;
  logic             pick_any;
  logic             start_ok;
  logic             in_lock;
  logic             last_eff;
  logic             accept;
  logic [DSIZE-1:0] cur_data;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  // awfull only gates the start of a packet; beats inside a packet stall on wfull alone.
  assign start_ok = (USE_AFULL == 0) || !awfull;
  assign in_lock  = (state_q == ARB_LOCK);
  assign last_eff = req_last[grant_id_q] | (beat_cnt_q == BEAT_MAX);
  assign accept   = in_lock & req_valid[grant_id_q] & ~wfull;

  assign winc      = accept;
  assign grant_vld = grant_vld_q;
  assign grant_id  = grant_id_q;

  always_comb begin
    cur_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id_q == IDW'(i)) cur_data = req_data[i*DSIZE +: DSIZE];
    end
  end

  always_comb begin
    req_ready = '0;
    if (in_lock && !wfull) req_ready[grant_id_q] = 1'b1;
  end

  always_comb begin
    wdata                 = '0;
    wdata[DSIZE-1:0]      = cur_data;
    wdata[WD_LAST]        = last_eff;
    wdata[WD_ID +: IDW]   = grant_id_q;
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= IDW'(NREQ - 1);
      beat_cnt_q  <= '0;
      grant_id_q  <= '0;
      grant_vld_q <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_any && start_ok) begin
            grant_id_q  <= pick_id;
            beat_cnt_q  <= '0;
            grant_vld_q <= 1'b1;
            state_q     <= ARB_LOCK;
          end
        end
        ARB_LOCK: begin
          if (accept) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (last_eff) begin
              rr_ptr_q    <= grant_id_q;
              grant_vld_q <= 1'b0;
              state_q     <= ARB_IDLE;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// tb/tb_async_fifo_wr_arbiter.sv - directed bench with per-cycle arbitration model and FIFO stand-in
module tb_async_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int DSIZE     = 32;
  localparam int MAX_BURST = 8;
  localparam int IDW       = 2;
  localparam int WW        = IDW + 1 + DSIZE;
  localparam int DEPTH     = 8;

  logic                  wclk = 1'b0;
  logic                  wrst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*DSIZE-1:0] req_data = '0;
  logic [NREQ-1:0]       req_last = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  winc;
  logic [WW-1:0]         wdata;
  logic                  wfull = 1'b0;
  logic                  awfull = 1'b0;
  logic                  grant_vld;
  logic [IDW-1:0]        grant_id;

  async_fifo_wr_arbiter #(
    .NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST), .USE_AFULL(1)
  ) dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .winc(winc), .wdata(wdata),
    .wfull(wfull), .awfull(awfull), .grant_vld(grant_vld), .grant_id(grant_id)
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] mkw(input int id, input logic last, input int data);
    return {IDW'(id), last, DSIZE'(data)};
  endfunction

  logic [DSIZE:0]  srcq [NREQ][$];
  logic [NREQ-1:0] gate = '1;
  logic [NREQ-1:0] acc_mask = '0;
  logic [WW-1:0]   fifo [$];
  logic [WW-1:0]   wr_log [$];
  logic [WW-1:0]   rd_log [$];
  int              gnt_log [$];
  int              gnt_cyc [$];
  logic            push_pend = 1'b0;
  logic            pop_pend = 1'b0;
  logic [WW-1:0]   push_word = '0;
  logic            rinc = 1'b1;
  logic            prev_vld = 1'b0;
  int              cyc = 0;
  int              max_fill = 0;
  int              overflow = 0;

  // Abstract arbitration state: current owner (-1 = none), beats sent in this grant, last served.
  int m_owner = -1;
  int m_cnt = 0;
  int m_last = NREQ - 1;

  // Requester sources and the FIFO stand-in advance just after each rising edge.
  always @(posedge wclk) begin : drv
    logic [DSIZE:0] head;
    cyc++;
    #1;
    if (push_pend) begin
      if (fifo.size() >= DEPTH) overflow++;
      fifo.push_back(push_word);
    end
    if (pop_pend) rd_log.push_back(fifo.pop_front());
    if (fifo.size() > max_fill) max_fill = fifo.size();
    wfull  = (fifo.size() >= DEPTH);
    awfull = (fifo.size() >= DEPTH - 1);
    for (int i = 0; i < NREQ; i++) begin
      if (acc_mask[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      if (srcq[i].size() > 0) begin
        head = srcq[i][0];
        req_valid[i] = gate[i];
        req_last[i]  = head[DSIZE];
        req_data[i*DSIZE +: DSIZE] = head[DSIZE-1:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*DSIZE +: DSIZE] = '0;
      end
    end
  end

  always @(negedge wclk) begin : cmp
    int g;
    int j;
    logic found;
    logic exp_last;
    logic [NREQ-1:0] exp_rdy;
    push_pend = 1'b0;
    pop_pend  = rinc && (fifo.size() > 0);
    acc_mask  = '0;
    if (wrst) begin
      chk("rst_winc", winc, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_grant_vld", grant_vld, 0);
      m_owner = -1; m_cnt = 0; m_last = NREQ - 1; prev_vld = 1'b0;
    end else begin
      if (grant_vld && !prev_vld) begin
        gnt_log.push_back(int'(grant_id));
        gnt_cyc.push_back(cyc);
      end
      prev_vld = grant_vld;
      if (m_owner < 0) begin
        chk("idle_winc", winc, 0);
        chk("idle_ready", req_ready, 0);
        chk("idle_grant_vld", grant_vld, 0);
        found = 1'b0;
        if (req_valid != '0 && !awfull) begin
          for (int k = 1; k <= NREQ; k++) begin
            j = (m_last + k) % NREQ;
            if (!found && req_valid[j]) begin
              found = 1'b1; m_owner = j; m_cnt = 0;
            end
          end
        end
      end else begin
        g = m_owner;
        exp_rdy = '0;
        if (!wfull) exp_rdy[g] = 1'b1;
        chk("lock_grant_vld", grant_vld, 1);
        chk("lock_grant_id", grant_id, g);
        chk("lock_ready", req_ready, exp_rdy);
        chk("lock_winc", winc, req_valid[g] && !wfull);
        if (req_valid[g] && !wfull) begin
          exp_last = req_last[g] || (m_cnt == MAX_BURST - 1);
          chk("wdata", wdata, mkw(g, exp_last, int'(req_data[g*DSIZE +: DSIZE])));
          m_cnt++;
          if (exp_last) begin m_last = g; m_owner = -1; end
        end
      end
      if (winc) begin
        push_pend = 1'b1; push_word = wdata; wr_log.push_back(wdata);
      end
      acc_mask = req_valid & req_ready;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge wclk);
  endtask

  task automatic at_drive();
    @(posedge wclk); #2;
  endtask

  task automatic clear_logs();
    wr_log.delete(); rd_log.delete(); gnt_log.delete(); gnt_cyc.delete();
  endtask

  task automatic push_pkt(input int r, input int n, input int base);
    logic l;
    for (int k = 0; k < n; k++) begin
      l = (k == n - 1);
      srcq[r].push_back({l, DSIZE'(base + k)});
    end
  endtask

  task automatic wait_idle(input string name);
    int t;
    logic busy;
    t = 0;
    busy = 1'b1;
    while (busy && t < 400) begin
      @(posedge wclk); t++;
      busy = grant_vld;
      for (int i = 0; i < NREQ; i++) if (srcq[i].size() > 0) busy = 1'b1;
    end
    chk({name, "_timeout"}, t >= 400, 0);
    tick(2);
  endtask

  task automatic wait_grant(input int id);
    int t;
    t = 0;
    do begin
      @(negedge wclk); #1; t++;
    end while (!(grant_vld && int'(grant_id) == id) && t < 200);
    chk("wait_grant_timeout", t >= 200, 0);
  endtask

  task automatic do_reset();
    at_drive();
    wrst = 1'b1;
    for (int i = 0; i < NREQ; i++) srcq[i].delete();
    tick(2); #2;
    wrst = 1'b0;
  endtask

  initial begin
    int t;
    tick(3); #2;
    wrst = 1'b0;
    @(negedge wclk); #1;
    chk("post_rst_grant_vld", grant_vld, 0);
    chk("post_rst_grant_id", grant_id, 0);
    chk("post_rst_winc", winc, 0);
    chk("post_rst_ready", req_ready, 0);

    // single 3-beat packet from requester 0
    clear_logs();
    at_drive();
    push_pkt(0, 3, 'hA);
    wait_idle("single");
    chk("single_len", wr_log.size(), 3);
    chk("single_b0", wr_log[0], 35'h0_0000_000A);
    chk("single_b1", wr_log[1], 35'h0_0000_000B);
    chk("single_b2", wr_log[2], 35'h1_0000_000C);
    chk("single_gnt", gnt_log[0], 0);
    chk("single_idle", grant_vld, 0);

    // round-robin with all four requesters holding 1-beat packets
    do_reset();
    clear_logs();
    at_drive();
    push_pkt(0, 1, 'h10); push_pkt(0, 1, 'h11);
    push_pkt(1, 1, 'h20); push_pkt(2, 1, 'h30); push_pkt(3, 1, 'h40);
    wait_idle("rr");
    chk("rr_len", gnt_log.size(), 5);
    chk("rr_g0", gnt_log[0], 0);
    chk("rr_g1", gnt_log[1], 1);
    chk("rr_g2", gnt_log[2], 2);
    chk("rr_g3", gnt_log[3], 3);
    chk("rr_g4", gnt_log[4], 0);
    for (int k = 0; k < 4; k++) chk("rr_gap", gnt_cyc[k+1] - gnt_cyc[k], 2);

    // two concurrent 4-beat packets must not interleave
    clear_logs();
    at_drive();
    push_pkt(1, 4, 'h100); push_pkt(2, 4, 'h200);
    wait_idle("nointlv");
    tick(4);
    chk("nointlv_len", rd_log.size(), 8);
    for (int k = 0; k < 4; k++) chk("nointlv_r1", rd_log[k], mkw(1, k == 3, 'h100 + k));
    for (int k = 0; k < 4; k++) chk("nointlv_r2", rd_log[k+4], mkw(2, k == 3, 'h200 + k));

    // 10-beat packet split at MAX_BURST, requester 0 slips in between
    clear_logs();
    at_drive();
    push_pkt(3, 10, 'h300);
    wait_grant(3);
    push_pkt(0, 1, 'h50);
    wait_idle("split");
    chk("split_len", wr_log.size(), 11);
    for (int k = 0; k < 8; k++) chk("split_a", wr_log[k], mkw(3, k == 7, 'h300 + k));
    chk("split_r0", wr_log[8], mkw(0, 1'b1, 'h50));
    chk("split_b9", wr_log[9], mkw(3, 1'b0, 'h308));
    chk("split_b10", wr_log[10], mkw(3, 1'b1, 'h309));

    // fill to wfull with reads off, then drain
    clear_logs();
    at_drive();
    rinc = 1'b0;
    push_pkt(0, 6, 'h600); push_pkt(1, 6, 'h700);
    tick(50);
    @(negedge wclk); #1;
    chk("full_fill", fifo.size(), DEPTH);
    chk("full_written", wr_log.size(), DEPTH);
    chk("full_held_vld", grant_vld, 1);
    chk("full_held_id", grant_id, 1);
    at_drive();
    rinc = 1'b1;
    wait_idle("full");
    tick(12);
    chk("full_rd_len", rd_log.size(), 12);
    for (int k = 0; k < 6; k++) chk("full_rd0", rd_log[k], mkw(0, k == 5, 'h600 + k));
    for (int k = 0; k < 6; k++) chk("full_rd1", rd_log[k+6], mkw(1, k == 5, 'h700 + k));

    // owner drops valid mid-packet: grant holds, requester 0 waits
    clear_logs();
    at_drive();
    push_pkt(2, 3, 'h800);
    wait_grant(2);
    gate[2] = 1'b0;
    push_pkt(0, 1, 'h900);
    tick(5);
    @(negedge wclk); #1;
    chk("hold_vld", grant_vld, 1);
    chk("hold_id", grant_id, 2);
    gate[2] = 1'b1;
    wait_idle("hold");
    chk("hold_len", wr_log.size(), 4);
    chk("hold_b0", wr_log[0], mkw(2, 1'b0, 'h800));
    chk("hold_b1", wr_log[1], mkw(2, 1'b0, 'h801));
    chk("hold_b2", wr_log[2], mkw(2, 1'b1, 'h802));
    chk("hold_r0", wr_log[3], mkw(0, 1'b1, 'h900));

    // reset after beat 2 of 5
    clear_logs();
    at_drive();
    push_pkt(1, 5, 'hA00);
    t = 0;
    do begin
      @(negedge wclk); #1; t++;
    end while (wr_log.size() < 2 && t < 200);
    chk("midrst_timeout", t >= 200, 0);
    @(posedge wclk); #2;
    wrst = 1'b1;
    #1;
    chk("midrst_winc", winc, 0);
    chk("midrst_ready", req_ready, 0);
    chk("midrst_vld", grant_vld, 0);
    chk("midrst_written", wr_log.size(), 2);
    for (int i = 0; i < NREQ; i++) srcq[i].delete();
    tick(2); #2;
    wrst = 1'b0;
    clear_logs();
    at_drive();
    push_pkt(3, 1, 'hB00); push_pkt(0, 1, 'hC00);
    wait_idle("midrst");
    chk("midrst_first", gnt_log[0], 0);
    chk("midrst_second", gnt_log[1], 3);
    chk("midrst_w0", wr_log[0], mkw(0, 1'b1, 'hC00));

    chk("max_fill", max_fill <= DEPTH, 1);
    chk("overflow", overflow, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
